vga_pixel_out: RTL and testbench

VGA timing generator and output stage at the display end of the video path. It scans the 800×525 raster and publishes pixelX/pixelY to the object drawers. It accepts the 24-bit colour that objects_mux returns PIPE_DELAY cycles later, and drives the registered RGB, sync and blank pins with matching alignment. It also emits a once-per-frame pulse that game logic uses to advance object state during vertical blanking.

---
 rtl/vga_pixel_out.sv | 209 ++++++++++++++++++++
 tb/tb_vga_pixel_out.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_out.sv
// ----------------------------------------------------------------------------
// vga_pixel_out
//
// VGA timing generator and pin output stage for an 800x525 raster.
// The free-running counters are published as pixelX/pixelY to the object
// drawers. The colour for each pixel comes back PIPE_DELAY cycles later.
// Sync, blank and hCount are delayed by the same amount so that all pins
// leave one output register together. The counter-to-pin latency is
// PIPE_DELAY+1 cycles.
//
// Optional feature: define VGA_TEST_PATTERN_EN to build the colour-bar test
// pattern. When it is built, testEnable selects the bars in the active area.
// When it is not built, testEnable is ignored.
//
// Ports
//   clk                      pixel clock, one pixel per cycle
//   resetN                   asynchronous active-low reset
//   redIn/greenIn/blueIn     colour for the pixel requested PIPE_DELAY cycles earlier
//   testEnable               test-pattern request
//   pixelX/pixelY            current scan position, straight from the counters
//   frameEnd                 one-cycle pulse at (0, V_ACTIVE), undelayed
//   vgaR/vgaG/vgaB           registered pin colour, zero outside the active area
//   vgaHS/vgaVS              active-low sync pins
//   vgaBlankN                high during the active area
//   vgaSyncN                 tied low (composite sync unused)
// ----------------------------------------------------------------------------
module vga_pixel_out #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIPE_DELAY = 1   // legal range 1..4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    input  logic        testEnable,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        frameEnd,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN,
    output logic        vgaSyncN
);

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hCount;
    logic [10:0] vCount;
    logic        hsRaw;
    logic        vsRaw;
    logic        activeRaw;

    // Bit 0 is the newest stage, and bit PIPE_DELAY-1 lines up with the incoming colour.
    logic [PIPE_DELAY-1:0] hsPipe;
    logic [PIPE_DELAY-1:0] vsPipe;
    logic [PIPE_DELAY-1:0] actPipe;
    logic                  actDly;

    logic [7:0] rNext;
    logic [7:0] gNext;
    logic [7:0] bNext;

    // ------------------------------------------------------------------
    // Raster counters: the column wrap and the row step share one edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hCount <= '0;
            vCount <= '0;
        end else if (hCount == H_LAST) begin
            hCount <= '0;
            vCount <= (vCount == V_LAST) ? '0 : vCount + 11'd1;
        end else begin
            hCount <= hCount + 11'd1;
        end
    end

    assign pixelX   = hCount;
    assign pixelY   = vCount;
    assign frameEnd = (hCount == '0) && (vCount == V_ACT);
    assign vgaSyncN = 1'b0;

    always_comb begin
        hsRaw     = !((hCount >= HS_START) && (hCount <= HS_END));
        vsRaw     = !((vCount >= VS_START) && (vCount <= VS_END));
        activeRaw = (hCount < H_ACT) && (vCount < V_ACT);
    end

    // ------------------------------------------------------------------
    // Alignment pipeline; the concat drops the oldest stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hsPipe  <= '1;
            vsPipe  <= '1;
            actPipe <= '0;
        end else begin
            hsPipe  <= (PIPE_DELAY)'({hsPipe, hsRaw});
            vsPipe  <= (PIPE_DELAY)'({vsPipe, vsRaw});
            actPipe <= (PIPE_DELAY)'({actPipe, activeRaw});
        end
    end

    assign actDly = actPipe[PIPE_DELAY-1];

`ifdef VGA_TEST_PATTERN_EN
    // The column index is only needed to pick a colour bar.
    logic [10:0] hPipe [PIPE_DELAY];
    logic [10:0] hDly;
    logic [2:0]  bar;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                hPipe[i] <= '0;
            end
        end else begin
            hPipe[0] <= hCount;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hPipe[i] <= hPipe[i-1];
            end
        end
    end

    assign hDly = hPipe[PIPE_DELAY-1];

    // Each bar is 80 pixels wide. The loop computes hDly / 80 for the active area.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hDly >= 11'(80 * k)) begin
                bar = 3'(k);
            end
        end
    end

    always_comb begin
        rNext = 8'h00;
        gNext = 8'h00;
        bNext = 8'h00;
        if (actDly) begin
            if (testEnable) begin
                // Bars: white, yellow, cyan, green, magenta, red, blue, black.
                rNext = bar[1] ? 8'h00 : 8'hFF;
                gNext = bar[2] ? 8'h00 : 8'hFF;
                bNext = bar[0] ? 8'h00 : 8'hFF;
            end else begin
                rNext = redIn;
                gNext = greenIn;
                bNext = blueIn;
            end
        end
    end
`else
    logic unused_testEnable;
    assign unused_testEnable = testEnable;

    always_comb begin
        rNext = 8'h00;
        gNext = 8'h00;
        bNext = 8'h00;
        if (actDly) begin
            rNext = redIn;
            gNext = greenIn;
            bNext = blueIn;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pin register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vgaHS     <= 1'b1;
            vgaVS     <= 1'b1;
            vgaBlankN <= 1'b0;
            vgaR      <= 8'h00;
            vgaG      <= 8'h00;
            vgaB      <= 8'h00;
        end else begin
            vgaHS     <= hsPipe[PIPE_DELAY-1];
            vgaVS     <= vsPipe[PIPE_DELAY-1];
            vgaBlankN <= actDly;
            vgaR      <= rNext;
            vgaG      <= gNext;
            vgaB      <= bNext;
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
// ----------------------------------------------------------------------------
// tb_vga_pixel_out
//
// Directed bench for vga_pixel_out. The bench uses two instances: one with
// PIPE_DELAY=1 and one with PIPE_DELAY=3. Both keep the full 800-pixel line.
// The vertical timing is shrunk to 6/2/2/2 lines so that a whole frame fits
// into a short run. Expected values come from the scan position that the
// bench derives from its own cycle count.
// ----------------------------------------------------------------------------
module tb_vga_pixel_out;

    localparam int HT = 800;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        resetN;
    logic        testEnable;
    logic [7:0]  r1, g1, b1, r3, g3, b3;
    logic [10:0] px1, py1, px3, py3;
    logic        fe1, fe3;
    logic [7:0]  vr1, vg1, vb1, vr3, vg3, vb3;
    logic        hs1, vs1, bn1, sn1, hs3, vs3, bn3, sn3;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int hsLow   = 0;
    int blankHi = 0;
    int vsLow   = 0;
    int feCnt   = 0;

    always #5 clk = ~clk;

    vga_pixel_out #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(1)
    ) u_dut1 (
        .clk(clk), .resetN(resetN), .redIn(r1), .greenIn(g1), .blueIn(b1),
        .testEnable(testEnable), .pixelX(px1), .pixelY(py1), .frameEnd(fe1),
        .vgaR(vr1), .vgaG(vg1), .vgaB(vb1), .vgaHS(hs1), .vgaVS(vs1),
        .vgaBlankN(bn1), .vgaSyncN(sn1)
    );

    vga_pixel_out #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(3)
    ) u_dut3 (
        .clk(clk), .resetN(resetN), .redIn(r3), .greenIn(g3), .blueIn(b3),
        .testEnable(testEnable), .pixelX(px3), .pixelY(py3), .frameEnd(fe3),
        .vgaR(vr3), .vgaG(vg3), .vgaB(vb3), .vgaHS(hs3), .vgaVS(vs3),
        .vgaBlankN(bn3), .vgaSyncN(sn3)
    );

    // ---------------- scan model ----------------
    function automatic int xof(int p); return p % HT; endfunction
    function automatic int yof(int p); return (p / HT) % VT; endfunction
    function automatic logic act(int p);
        if (p < 0) return 1'b0;
        return (xof(p) < 640) && (yof(p) < VA);
    endfunction
    // testEnable is high throughout line 2 of the first frame.
    function automatic logic te_at(int c); return (c >= 1600) && (c < 2400); endfunction
    function automatic logic pat_on(int c);
`ifdef VGA_TEST_PATTERN_EN
        return te_at(c - 1);
`else
        return 1'b0;
`endif
    endfunction
    // Upstream colour emulates the registered mux: R=x, G=~x, B=A5; R/G=FF in blanking.
    function automatic logic [7:0] in_r(int p);
        return act(p) ? 8'(xof(p)) : 8'hFF;
    endfunction
    function automatic logic [7:0] in_g(int p);
        return act(p) ? ~8'(xof(p)) : 8'hFF;
    endfunction
    function automatic logic [7:0] bar_col(int x, int ch);
        int b = x / 80;
        if (ch == 0) return (b == 0 || b == 1 || b == 4 || b == 5) ? 8'hFF : 8'h00;
        if (ch == 1) return (b < 4) ? 8'hFF : 8'h00;
        return (b % 2 == 0) ? 8'hFF : 8'h00;
    endfunction
    function automatic logic exp_hs(int c, int pd);
        int p = c - pd - 1;
        if (p < 0) return 1'b1;
        return !((xof(p) >= 656) && (xof(p) <= 751));
    endfunction
    function automatic logic exp_vs(int c, int pd);
        int p = c - pd - 1;
        if (p < 0) return 1'b1;
        return !((yof(p) >= VA + VF) && (yof(p) < VA + VF + VS));
    endfunction
    function automatic logic [7:0] exp_col(int c, int pd, int ch);
        int p = c - pd - 1;
        if (!act(p)) return 8'h00;
        if (pat_on(c)) return bar_col(xof(p), ch);
        if (ch == 0) return in_r(p);
        if (ch == 1) return in_g(p);
        return 8'hA5;
    endfunction

    // ---------------- bench tasks ----------------
    task automatic chk(input string tag, input int obs, input int exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        r1 = in_r(cyc - 1);
        g1 = in_g(cyc - 1);
        b1 = 8'hA5;
        r3 = in_r(cyc - 3);
        g3 = in_g(cyc - 3);
        b3 = 8'hA5;
        testEnable = te_at(cyc);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1 drive();
        @(negedge clk);
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_px"}, int'(px1), 0);
        chk({tag, "_py"}, int'(py1), 0);
        chk({tag, "_fe"}, int'(fe1), 0);
        chk({tag, "_hs"}, int'(hs1), 1);
        chk({tag, "_vs"}, int'(vs1), 1);
        chk({tag, "_bn"}, int'(bn1), 0);
        chk({tag, "_r"}, int'(vr1), 0);
        chk({tag, "_g"}, int'(vg1), 0);
        chk({tag, "_b"}, int'(vb1), 0);
        chk({tag, "_bn3"}, int'(bn3), 0);
        chk({tag, "_r3"}, int'(vr3), 0);
    endtask

    task automatic check_all();
        chk("pixelX", int'(px1), xof(cyc));
        chk("pixelY", int'(py1), yof(cyc));
        chk("frameEnd", int'(fe1), int'(xof(cyc) == 0 && yof(cyc) == VA));
        chk("vgaHS", int'(hs1), int'(exp_hs(cyc, 1)));
        chk("vgaVS", int'(vs1), int'(exp_vs(cyc, 1)));
        chk("vgaBlankN", int'(bn1), int'(act(cyc - 2)));
        chk("vgaR", int'(vr1), int'(exp_col(cyc, 1, 0)));
        chk("vgaG", int'(vg1), int'(exp_col(cyc, 1, 1)));
        chk("vgaB", int'(vb1), int'(exp_col(cyc, 1, 2)));
        chk("vgaSyncN", int'(sn1), 0);
        chk("pixelX_d3", int'(px3), xof(cyc));
        chk("vgaHS_d3", int'(hs3), int'(exp_hs(cyc, 3)));
        chk("vgaVS_d3", int'(vs3), int'(exp_vs(cyc, 3)));
        chk("vgaBlankN_d3", int'(bn3), int'(act(cyc - 4)));
        chk("vgaR_d3", int'(vr3), int'(exp_col(cyc, 3, 0)));
        chk("vgaG_d3", int'(vg3), int'(exp_col(cyc, 3, 1)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetN = 1'b1;
        cyc    = 0;
        drive();
        testEnable = 1'b1;  // must have no effect while in reset
        #1 resetN = 1'b0;
        #1 check_reset_pins("rst_async");
        repeat (3) @(negedge clk);
        check_reset_pins("rst_held");

        // Release the reset midway between clock edges. Cycle 0 shows pixel (0,0).
        resetN = 1'b1;
        cyc    = 0;
        drive();
        #1 check_all();

        while (cyc < 9600 + 3 * HT + 300) begin
            step();
            check_all();
            if (cyc >= 2 && cyc < 802) begin
                hsLow   += int'(!hs1);
                blankHi += int'(bn1);
            end
            if (cyc >= 2 && cyc < 9602) vsLow += int'(!vs1);
            if (cyc < 9600) feCnt += int'(fe1);
            case (cyc)
                1:    chk("blank_before_rise", int'(bn1), 0);
                2:    chk("blank_rise", int'(bn1), 1);
                4:    chk("blank_rise_d3", int'(bn3), 1);
                657:  chk("hs_before_fall", int'(hs1), 1);
                658:  chk("hs_fall", int'(hs1), 0);
                753:  chk("hs_last_low", int'(hs1), 0);
                754:  chk("hs_rise", int'(hs1), 1);
                9599: chk("py_last", int'(py1), VT - 1);
                9600: chk("py_wrap", int'(py1), 0);
`ifdef VGA_TEST_PATTERN_EN
                1602: chk("tp_x0_rgb", int'({vr1, vg1, vb1}), 'hFFFFFF);
                2002: chk("tp_x400_rgb", int'({vr1, vg1, vb1}), 'hFF0000);
                2202: chk("tp_x600_rgb", int'({vr1, vg1, vb1}), 'h000000);
`else
                1602: chk("tp_x0_rgb", int'({vr1, vg1, vb1}), 'h00FFA5);
                2002: chk("tp_x400_rgb", int'({vr1, vg1, vb1}), 'h906FA5);
                2202: chk("tp_x600_rgb", int'({vr1, vg1, vb1}), 'h58A7A5);
`endif
                default: ;
            endcase
        end

        chk("hs_low_per_line", hsLow, 96);
        chk("blank_high_per_line", blankHi, 640);
        chk("vs_low_per_frame", vsLow, VS * HT);
        chk("frameEnd_per_frame", feCnt, 1);

        // Assert the reset mid-frame at (300,3). The pins must drop without waiting for a clock.
        chk("pre_reset_px", int'(px1), 300);
        chk("pre_reset_py", int'(py1), 3);
        chk("pre_reset_bn", int'(bn1), 1);
        resetN = 1'b0;
        #1 check_reset_pins("midrst_async");
        repeat (2) @(negedge clk);
        check_reset_pins("midrst_held");

        resetN = 1'b1;
        cyc    = 0;
        drive();
        #1 check_all();
        repeat (810) begin
            step();
            check_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
